// File: rtl/fetch_sequencer.sv
// Fetch controller for the 4K x 8 program ROM: assembles short/long instructions
// and hands them to decode over valid/ready. Optional wrap trap: FETCH_WRAP_TRAP_EN.
module fetch_sequencer #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   output logic [ADDR_W-1:0] PC,
   input  logic [DATA_W-1:0] program_byte,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [3:0]        opcode,
   output logic [3:0]        operand,
   output logic [7:0]        imm,
   output logic              instr_long,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr
`ifdef FETCH_WRAP_TRAP_EN
   ,
   output logic              pc_wrap
`endif
);

   localparam logic [1:0] S_FETCH1 = 2'd0;
   localparam logic [1:0] S_FETCH2 = 2'd1;
   localparam logic [1:0] S_VALID  = 2'd2;
`ifdef FETCH_WRAP_TRAP_EN
   localparam logic [1:0] S_HALT   = 2'd3;
`endif
   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [3:0]        opcode_q, opcode_d;
   logic [3:0]        operand_q, operand_d;
   logic [7:0]        imm_q, imm_d;
   logic              long_q, long_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic [ADDR_W-1:0] pc_inc;
`ifdef FETCH_WRAP_TRAP_EN
   logic              wrap_q, wrap_d;
   logic              pc_top;

   assign pc_top = &pc_q;
`endif

   // Natural modulo-2^ADDR_W wrap: 0xFFF + 1 -> 0x000.
   assign pc_inc = pc_q + ADDR_W'(1);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      imm_d     = imm_q;
      long_d    = long_q;
      ipc_d     = ipc_q;
`ifdef FETCH_WRAP_TRAP_EN
      wrap_d    = wrap_q;
`endif
      case (state_q)
         S_FETCH1: begin
            if (enable) begin
               opcode_d  = program_byte[7:4];
               operand_d = program_byte[3:0];
               ipc_d     = pc_q;
               pc_d      = pc_inc;
               if (program_byte[7]) begin
                  state_d = S_FETCH2;
               end else begin
                  long_d  = 1'b0;
                  imm_d   = '0;
                  state_d = S_VALID;
               end
`ifdef FETCH_WRAP_TRAP_EN
               if (pc_top) begin
                  state_d = S_HALT;
                  wrap_d  = 1'b1;
               end
`endif
            end
         end
         S_FETCH2: begin
            if (enable) begin
               imm_d   = program_byte[7:0];
               long_d  = 1'b1;
               pc_d    = pc_inc;
               state_d = S_VALID;
`ifdef FETCH_WRAP_TRAP_EN
               if (pc_top) begin
                  state_d = S_HALT;
                  wrap_d  = 1'b1;
               end
`endif
            end
         end
         S_VALID: begin
            // PC already points past the instruction unless a jump is taken.
            if (instr_ready) begin
               state_d = S_FETCH1;
               if (load_en) pc_d = load_addr;
            end
         end
         default: begin
`ifndef FETCH_WRAP_TRAP_EN
            state_d = S_FETCH1;
`endif
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH1;
         pc_q      <= PC_RST;
         opcode_q  <= '0;
         operand_q <= '0;
         imm_q     <= '0;
         long_q    <= 1'b0;
         ipc_q     <= '0;
`ifdef FETCH_WRAP_TRAP_EN
         wrap_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         imm_q     <= imm_d;
         long_q    <= long_d;
         ipc_q     <= ipc_d;
`ifdef FETCH_WRAP_TRAP_EN
         wrap_q    <= wrap_d;
`endif
      end
   end

   assign PC          = pc_q;
   assign instr_valid = (state_q == S_VALID);
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign imm         = imm_q;
   assign instr_long  = long_q;
   assign instr_pc    = ipc_q;
`ifdef FETCH_WRAP_TRAP_EN
   assign pc_wrap     = wrap_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch controller that sequences the 4K x 8 program ROM.
- Drives the ROM address `PC` and samples the combinational `program_byte`.
- Assembles 1-byte (short) and 2-byte (long) instructions and presents them to the decode stage over a valid/ready handshake.
- Owns the program counter: increments it per byte, wraps it at the top of memory, and loads it on a taken jump.

Parameters:
- ADDR_W, 12, ROM address width; the PC wraps modulo 2^ADDR_W.
- DATA_W, 8, ROM word width.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  fetch enable; when 0, the FETCH states freeze.
- PC  out  ADDR_W  ROM address; goes to the ROM `PC` input.
- program_byte  in  DATA_W  ROM read data, valid in the same cycle as `PC`.
- instr_valid  out  1  an assembled instruction is presented.
- instr_ready  in  1  decode accepts the instruction.
- opcode  out  4  first byte [7:4].
- operand  out  4  first byte [3:0].
- imm  out  8  second byte of a long instruction; 0 for short.
- instr_long  out  1  1 = 2-byte instruction.
- instr_pc  out  ADDR_W  address of the instruction's first byte.
- load_en  in  1  jump taken; sampled only on handshake.
- load_addr  in  ADDR_W  jump target.

Behaviour:
- Reset (reset==0, asynchronous):
  - PC=RESET_PC, state=FETCH1, instr_valid=0.
  - opcode, operand, imm, instr_long, instr_pc all 0.
  - Reset mid-instruction discards any partial assembly.
- FETCH1:
  - If enable=1: latch program_byte[7:4]->opcode and [3:0]->operand, PC->instr_pc, then PC<=PC+1.
  - If program_byte[7]=0: instr_long<=0, imm<=0, go to VALID.
  - If program_byte[7]=1: go to FETCH2.
  - If enable=0: hold state and PC.
- FETCH2:
  - If enable=1: imm<=program_byte, instr_long<=1, PC<=PC+1, go to VALID.
  - If enable=0: hold.
- VALID:
  - instr_valid=1 and all instruction outputs stable until the handshake (instr_valid & instr_ready).
  - On handshake with load_en=1: PC<=load_addr, go to FETCH1.
  - On handshake with load_en=0: PC unchanged (already points at the next instruction), go to FETCH1.
  - enable is ignored in VALID.
- instr_valid is registered and deasserts in the cycle after the handshake.
- load_en is ignored outside a handshake.
- Latency with instr_ready=1 and enable=1:
  - Short instruction: 2 cycles (FETCH1, VALID).
  - Long instruction: 3 cycles (FETCH1, FETCH2, VALID).
  - First instr_valid appears 1 cycle (short) or 2 cycles (long) after reset release.
- Arithmetic:
  - PC+1 is modulo 2^ADDR_W: 0xFFF -> 0x000.
  - A long instruction whose first byte is at 0xFFF takes its second byte from 0x000.
- load_addr is used verbatim; any value is legal.

Optional Feature:
- Macro FETCH_WRAP_TRAP_EN.
- Defined:
  - Adds output `pc_wrap` (1 bit, reset 0).
  - Any increment from 0xFFF (in FETCH1 or FETCH2) sets `pc_wrap`=1 and enters state HALT.
  - HALT: instr_valid=0 and PC frozen at 0x000; exited only by reset.
  - A jump load to any address never triggers the trap.
  - The instruction being assembled at the wrap is discarded.
- Not defined:
  - No `pc_wrap` port and no HALT state.
  - PC wraps silently as described in Behaviour.

Test Plan:
- Short stream: ROM[0]=0x35, ROM[1]=0x12, instr_ready=1 -> first handshake opcode=3, operand=5, imm=0, instr_long=0, instr_pc=0x000; next opcode=1, operand=2, instr_pc=0x001; valid every 2nd cycle.
- Long instruction: ROM[2]=0x9A, ROM[3]=0x4C -> opcode=9, operand=0xA, imm=0x4C, instr_long=1, instr_pc=0x002; PC=0x004 after the handshake.
- Backpressure/enable:
  - Hold instr_ready=0 for 5 cycles at VALID -> outputs and PC unchanged, instr_valid stays 1.
  - enable=0 during FETCH2 for 3 cycles -> PC frozen, then completes normally.
- Jump: handshake with load_en=1, load_addr=0x7F0, ROM[0x7F0]=0x21 -> PC=0x7F0 the next cycle; next instruction opcode=2, instr_pc=0x7F0. load_en=1 while instr_ready=0 -> ignored.
- Wrap: jump to 0xFFF with ROM[0xFFF]=0x80, ROM[0x000]=0x55:
  - Trap undefined -> imm=0x55, instr_pc=0xFFF, PC=0x001 after.
  - Trap defined -> pc_wrap=1, HALT, no further instr_valid.
- Async reset asserted in FETCH2 mid-cycle -> instr_valid=0 and PC=0x000 immediately; after release, fetch restarts from 0x000.
